// File: rtl/pio_event_sequencer.sv
// Avalon-MM master for a 4-bit edge-capturing switch PIO: programs the irq mask,
// services each interrupt (read/clear edges, sample levels) and queues event records.
module pio_event_sequencer #(
  parameter int                WIDTH      = 4,
  parameter logic [WIDTH-1:0]  MASK_INIT  = 4'hF,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [31:0]       pio_writedata,
  input  logic [31:0]       pio_readdata,
  input  logic              pio_irq,
  input  logic              mask_wr,
  input  logic [WIDTH-1:0]  mask_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [WIDTH-1:0]  ev_edges,
  output logic [WIDTH-1:0]  ev_level,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_RD_EDGE   = 3'd2,
    S_RD_EDGE_W = 3'd3,
    S_CLR       = 3'd4,
    S_RD_DATA   = 3'd5,
    S_RD_DATA_W = 3'd6,
    S_PUSH      = 3'd7
  } state_t;

  state_t             r_state, w_next;
  logic               r_cs, w_cs;
  logic               r_wn, w_wn;
  logic [1:0]         r_addr, w_addr;
  logic [31:0]        r_wd, w_wd;
  logic               r_busy;
  logic [WIDTH-1:0]   r_edges, r_level, r_mask;
  logic               r_pend, r_ovf;
  logic               w_push, w_pop, w_do_push, w_drop, w_empty, w_full, w_issue_mask;
  logic [WIDTH-1:0]   w_rd_bits;
  logic               w_unused;
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0]   r_mem_edges [FIFO_DEPTH];
  logic [WIDTH-1:0]   r_mem_level [FIFO_DEPTH];

  assign w_rd_bits = pio_readdata[WIDTH-1:0];
  assign w_unused  = &{1'b0, pio_readdata[31:WIDTH]};

  // Next state, plus the access the next state performs (registered below so it
  // appears on the bus during that state).
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = r_addr;
    w_wd   = 32'd0;
    case (r_state)
      S_INIT:      if (r_cs) w_next = S_IDLE; else w_next = S_INIT;
      S_IDLE: begin
        if (r_pend)       w_next = S_INIT;
        else if (pio_irq) w_next = S_RD_EDGE;
        else              w_next = S_IDLE;
      end
      S_RD_EDGE:   w_next = S_RD_EDGE_W;
      S_RD_EDGE_W: if (w_rd_bits == {WIDTH{1'b0}}) w_next = S_IDLE; else w_next = S_CLR;
      S_CLR:       w_next = S_RD_DATA;
      S_RD_DATA:   w_next = S_RD_DATA_W;
      S_RD_DATA_W: w_next = S_PUSH;
      S_PUSH: begin
        w_push = 1'b1;
        w_next = S_IDLE;
      end
      default:     w_next = S_INIT;
    endcase
    case (w_next)
      S_INIT: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd2;
        w_wd = {{(32-WIDTH){1'b0}}, r_mask};
      end
      S_RD_EDGE: begin
        w_cs = 1'b1; w_addr = 2'd3;
      end
      // Write-1-to-clear only the bits just read; later edges stay captured.
      S_CLR: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd3;
        w_wd = {{(32-WIDTH){1'b0}}, w_rd_bits};
      end
      S_RD_DATA: begin
        w_cs = 1'b1; w_addr = 2'd0;
      end
      default: begin
        w_cs = 1'b0;
      end
    endcase
  end

  assign w_issue_mask = (w_next == S_INIT);

  // State and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_addr  <= 2'd0;
      r_wd    <= 32'd0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_addr  <= w_addr;
      r_wd    <= w_wd;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Captured edge/level data and the pending mask request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edges <= {WIDTH{1'b0}};
      r_level <= {WIDTH{1'b0}};
      r_mask  <= MASK_INIT;
      r_pend  <= 1'b1;
    end else begin
      if (r_state == S_RD_EDGE_W) r_edges <= w_rd_bits;
      if (r_state == S_RD_DATA_W) r_level <= w_rd_bits;
      if (mask_wr) begin
        r_mask <= mask_in;
        r_pend <= 1'b1;
      end else if (w_issue_mask) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && ev_ready;
  // A pop in the same cycle frees the slot for the push.
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      if (w_drop)            r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_edges[r_wptr[AW-1:0]] <= r_edges;
      r_mem_level[r_wptr[AW-1:0]] <= r_level;
    end
  end

  assign pio_address    = r_addr;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = r_wd;
  assign busy           = r_busy;
  assign overflow       = r_ovf;
  assign ev_valid       = !w_empty;
  assign ev_edges       = r_mem_edges[r_rptr[AW-1:0]];
  assign ev_level       = r_mem_level[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Directed bench for pio_event_sequencer with a behavioural edge-capturing PIO model
// and a bus-access log checked against hand-computed cycle numbers.
module tb_pio_event_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata, pio_readdata;
  logic        pio_irq;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_in = 4'h0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_edges, ev_level;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic        busy;

  logic [3:0]  sw = 4'h0;
  logic        force_irq = 1'b0;
  logic [3:0]  m_prev, m_edge, m_mask;
  logic [31:0] m_rd;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  addr;
    logic        wn;
    logic [31:0] wd;
  } acc_t;
  acc_t log_q[$];

  always #5 clk = ~clk;

  pio_event_sequencer #(.WIDTH(4), .MASK_INIT(4'hF), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .mask_wr(mask_wr), .mask_in(mask_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_edges(ev_edges), .ev_level(ev_level),
    .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
  );

  // PIO slave model: rising-edge capture, W1C edge register, registered readdata
  assign pio_readdata = m_rd;
  assign pio_irq      = (|(m_edge & m_mask)) | force_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev <= 4'h0; m_edge <= 4'h0; m_mask <= 4'h0; m_rd <= 32'd0;
    end else begin
      m_prev <= sw;
      m_edge <= (m_edge & ~((pio_chipselect && !pio_write_n && pio_address == 2'd3)
                            ? pio_writedata[3:0] : 4'h0)) | (sw & ~m_prev);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata[3:0];
      case (pio_address)
        2'd0:    m_rd <= {28'd0, sw};
        2'd2:    m_rd <= {28'd0, m_mask};
        2'd3:    m_rd <= {28'd0, m_edge};
        default: m_rd <= 32'd0;
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset_n && pio_chipselect)
      log_q.push_back('{cyc: cyc, addr: pio_address, wn: pio_write_n, wd: pio_writedata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input int ecyc, input logic [1:0] eaddr,
                           input logic ewn, input logic chk_wd, input logic [31:0] ewd);
    check({tag, "_present"}, 32'(log_q.size() > idx), 32'd1);
    if (log_q.size() > idx) begin
      check({tag, "_cyc"},  log_q[idx].cyc,  ecyc);
      check({tag, "_addr"}, 32'(log_q[idx].addr), 32'(eaddr));
      check({tag, "_wn"},   32'(log_q[idx].wn),   32'(ewn));
      if (chk_wd) check({tag, "_wd"}, log_q[idx].wd, ewd);
    end
  endtask

  task automatic wait_ev(output int c);
    c = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ev_valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic pop_check(input string tag, input logic [3:0] e, input logic [3:0] l);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_edges"}, 32'(ev_edges), 32'(e));
    check({tag, "_level"}, 32'(ev_level), 32'(l));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t, cv;
    logic [3:0] seq [4];
    seq[0] = 4'h1; seq[1] = 4'h3; seq[2] = 4'h7; seq[3] = 4'hF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs",   32'(pio_chipselect), 32'd0);
    check("rst_wn",   32'(pio_write_n),    32'd1);
    check("rst_addr", 32'(pio_address),    32'd0);
    check("rst_wd",   pio_writedata,       32'd0);
    check("rst_evv",  32'(ev_valid),       32'd0);
    check("rst_ovf",  32'(overflow),       32'd0);
    check("rst_busy", 32'(busy),           32'd1);
    c = cyc;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("init_n", log_q.size(), 32'd1);
    check_acc("init_wr", 0, c + 1, 2'd2, 1'b0, 1'b1, 32'h0000000F);
    check("init_busy", 32'(busy),     32'd0);
    check("init_evv",  32'(ev_valid), 32'd0);

    // Single event on bit 1
    log_q.delete();
    c = cyc; sw = 4'h2; t = c + 1;
    wait_ev(cv);
    check("ev1_lat", cv, t + 7);
    check("ev1_n", log_q.size(), 32'd3);
    check_acc("ev1_rde", 0, t + 1, 2'd3, 1'b1, 1'b0, 32'd0);
    check_acc("ev1_clr", 1, t + 3, 2'd3, 1'b0, 1'b1, 32'h2);
    check_acc("ev1_rdd", 2, t + 4, 2'd0, 1'b1, 1'b0, 32'd0);
    check("ev1_busy", 32'(busy), 32'd0);
    pop_check("ev1", 4'h2, 4'h2);
    check("ev1_empty", 32'(ev_valid), 32'd0);

    // Bit 2 event, bit 0 rises during its CLR: back-to-back second event
    log_q.delete();
    c = cyc; sw = 4'h6; t = c + 1;
    repeat (4) @(negedge clk);
    sw = 4'h7;
    repeat (13) @(negedge clk);
    check("b2b_n", log_q.size(), 32'd6);
    check_acc("b2b_rde1", 0, t + 1,  2'd3, 1'b1, 1'b0, 32'd0);
    check_acc("b2b_clr1", 1, t + 3,  2'd3, 1'b0, 1'b1, 32'h4);
    check_acc("b2b_rde2", 3, t + 8,  2'd3, 1'b1, 1'b0, 32'd0);
    check_acc("b2b_clr2", 4, t + 10, 2'd3, 1'b0, 1'b1, 32'h1);
    pop_check("b2b1", 4'h4, 4'h7);
    pop_check("b2b2", 4'h1, 4'h7);
    check("b2b_empty", 32'(ev_valid), 32'd0);

    // Five events into a four-deep FIFO
    sw = 4'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sw = seq[i];
      repeat (12) @(negedge clk);
    end
    check("full_ovf0", 32'(overflow), 32'd0);
    sw = 4'h0;
    repeat (2) @(negedge clk);
    sw = 4'h3;
    repeat (12) @(negedge clk);
    check("full_ovf1", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("full_ovfclr", 32'(overflow), 32'd0);
    pop_check("drain1", 4'h1, 4'h1);
    pop_check("drain2", 4'h2, 4'h3);
    pop_check("drain3", 4'h4, 4'h7);
    pop_check("drain4", 4'h8, 4'hF);
    check("drain_empty", 32'(ev_valid), 32'd0);

    // Mask request while a service is in progress
    log_q.delete();
    c = cyc; sw = 4'h7; t = c + 1;
    repeat (3) @(negedge clk);
    check("mask_busy", 32'(busy), 32'd1);
    mask_wr = 1'b1; mask_in = 4'h3;
    @(negedge clk);
    mask_wr = 1'b0;
    repeat (9) @(negedge clk);
    check("mask_n", log_q.size(), 32'd4);
    check_acc("mask_clr", 1, t + 3, 2'd3, 1'b0, 1'b1, 32'h4);
    check_acc("mask_wr",  3, t + 8, 2'd2, 1'b0, 1'b1, 32'h3);
    pop_check("mask_ev", 4'h4, 4'h7);

    // Spurious irq: edge capture reads back zero
    log_q.delete();
    c = cyc; force_irq = 1'b1; t = c;
    @(negedge clk);
    force_irq = 1'b0;
    check("spur_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("spur_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("spur_idle", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("spur_n", log_q.size(), 32'd1);
    check_acc("spur_rde", 0, t + 1, 2'd3, 1'b1, 1'b0, 32'd0);
    check("spur_evv", 32'(ev_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_event_sequencer.md
Name: pio_event_sequencer

Overview:
- Avalon-MM master that owns one 4-bit edge-capturing switch PIO slave: programs its interrupt mask, services its irq, and packages each interrupt into an event record.
- Service sequence: read edge capture, clear exactly those bits, sample the input levels, push the result into a small FIFO.
- Engine-control logic consumes events through a valid/ready stream.
- Replaces CPU interrupt handling of the switch PIO so switch events are handled deterministically in hardware.

Parameters:
- WIDTH, 4, number of PIO input bits; also the width of mask, edges and levels.
- MASK_INIT, 4'hF, irq mask written to the PIO after reset.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pio_address  out  2  PIO register select: 0 = data, 2 = irq mask, 3 = edge capture.
- pio_chipselect  out  1  PIO access strobe, one cycle per access.
- pio_write_n  out  1  0 = write, 1 = read.
- pio_writedata  out  32  write data; bits above WIDTH are 0.
- pio_readdata  in  32  PIO registered read data.
- pio_irq  in  1  PIO interrupt.
- mask_wr  in  1  one-cycle request to reprogram the mask.
- mask_in  in  WIDTH  new mask value, sampled when mask_wr=1.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head entry.
- ev_edges  out  WIDTH  head entry: edge bits captured.
- ev_level  out  WIDTH  head entry: input levels after the clear.
- overflow  out  1  sticky: an event was dropped.
- overflow_clr  in  1  clears overflow.
- busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM to INIT; FIFO emptied.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - ev_valid=0, overflow=0, pending-mask register = MASK_INIT with pending flag set.
- Reset mid-sequence aborts the access in flight; no partial event is pushed.
- Read timing: the PIO registers readdata every clock from the address. Data for an address driven in cycle N is sampled at the end of cycle N+1.
- Outputs are registered; the FSM drives at most one access per state.
- FSM states:
  - INIT: write pending mask to address 2 (chipselect=1, write_n=0); clear pending flag; -> IDLE.
  - IDLE:
    - If pending flag is set -> INIT (mask update takes priority over irq).
    - Else if pio_irq=1 -> RD_EDGE.
    - Else stay.
  - RD_EDGE: read address 3 -> RD_EDGE_W.
  - RD_EDGE_W: chipselect=0; latch edges = pio_readdata[WIDTH-1:0].
    - If edges==0 (spurious) -> IDLE.
    - Else -> CLR.
  - CLR: write address 3 with writedata = edges. This is write-1-to-clear of only the latched bits, so an edge arriving after RD_EDGE survives. -> RD_DATA.
  - RD_DATA: read address 0 -> RD_DATA_W.
  - RD_DATA_W: latch level = pio_readdata[WIDTH-1:0] -> PUSH.
  - PUSH: enqueue {edges, level} if the FIFO is not full; otherwise drop it and set overflow. -> IDLE.
- mask_wr in any state sets the pending flag and loads mask_in; the last request wins. It is applied at the next IDLE.
- Latency: pio_irq high in an IDLE cycle T gives chipselect at T+1 (RD_EDGE), T+3 (CLR) and T+4 (RD_DATA); PUSH at T+6; ev_valid=1 at T+7 when the FIFO was empty.
- Back-to-back: if irq is still high on return to IDLE (new edge during the service), a new sequence starts the next cycle.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full when the MSBs differ and the low bits match.
  - ev_edges and ev_level show the head entry combinationally; their values are don't-care when ev_valid=0.
  - A pop occurs when ev_valid & ev_ready.
  - A push and a pop in the same cycle on a full FIFO: the pop is counted first, so the push succeeds and no overflow is raised.
  - A push and a pop on an empty FIFO: push only (ev_valid was 0).
- overflow: a set in the same cycle as overflow_clr wins (overflow stays 1).
- busy = (state != IDLE).

Test Plan:
- Reset release, no activity -> a single write at address 2, writedata=0x0000000F, 1 cycle after reset release; then IDLE, busy=0, ev_valid=0.
- Switch bit 1 rises (PIO model edge_capture=0x2, level 0x2) -> reads at addresses 3 then 0; write at address 3 with 0x2; event edges=0x2, level=0x2; ev_valid at T+7.
- Bit 0 rises during CLR of a bit-2 event -> first event edges=0x4; bit 0 stays captured, irq stays high, so a second event edges=0x1 follows without an idle gap.
- ev_ready=0, 5 events with FIFO_DEPTH=4 -> 4 entries retained in order; overflow=1; overflow_clr -> 0; draining returns events 1-4.
- mask_wr with mask_in=0x3 while busy -> the current event completes; then a write at address 2 with 0x3 before the next irq service.
- irq pulse with edge_capture reading 0 -> no CLR write, no push; back to IDLE at T+3.
